// File: rtl/multicycle_ctrl.sv
// Multicycle CPU control FSM: FETCH/DECODE/EXEC/MEM/WB/HALT with Moore outputs.
// Define MC_PERF_CNT_EN to build the retired-instruction counter; otherwise retired is tied to 0.
module multicycle_ctrl (
  input  logic        clk,
  input  logic        rstd,
  input  logic [5:0]  opcode,
  input  logic [4:0]  wa,
  input  logic        zero,
  input  logic        mem_ack,
  output logic        mem_req,
  output logic        mem_we,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic        rf_wren,
  output logic        alu_src_imm,
  output logic        wb_sel_mem,
  output logic        halted,
  output logic        illegal,
  output logic [31:0] retired
);

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_e;
  typedef enum logic [2:0] {C_RTYPE, C_ADDI, C_LW, C_SW, C_BEQ, C_J, C_HALT, C_ILL} cls_e;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_ADDI  = 6'd1;
  localparam logic [5:0] OP_LW    = 6'd16;
  localparam logic [5:0] OP_SW    = 6'd24;
  localparam logic [5:0] OP_BEQ   = 6'd32;
  localparam logic [5:0] OP_J     = 6'd40;
  localparam logic [5:0] OP_HALT  = 6'd63;

  localparam logic [1:0] PC_SEQ = 2'd0;
  localparam logic [1:0] PC_BR  = 2'd1;
  localparam logic [1:0] PC_JMP = 2'd2;

  state_e state_q, state_d;
  cls_e   cls_q, cls_d, op_cls;
  logic   mem_req_q, mem_we_q, rf_wren_q, alu_src_imm_q, wb_sel_mem_q, halted_q, illegal_q;
  logic   fetch_ack;

  always_comb begin
    case (opcode)
      OP_RTYPE: op_cls = C_RTYPE;
      OP_ADDI:  op_cls = C_ADDI;
      OP_LW:    op_cls = C_LW;
      OP_SW:    op_cls = C_SW;
      OP_BEQ:   op_cls = C_BEQ;
      OP_J:     op_cls = C_J;
      OP_HALT:  op_cls = C_HALT;
      default:  op_cls = C_ILL;
    endcase
  end

  // The first cycle after reset release has mem_req low, so an early ack is not a fetch.
  assign fetch_ack = (state_q == FETCH) && mem_req_q && mem_ack;
  assign ir_we     = fetch_ack;

  always_comb begin
    state_d = state_q;
    cls_d   = cls_q;
    case (state_q)
      FETCH: if (fetch_ack) state_d = DECODE;
      DECODE: begin
        cls_d = op_cls;
        case (op_cls)
          C_HALT:  state_d = HALT;
          C_ILL:   state_d = FETCH;
          default: state_d = EXEC;
        endcase
      end
      EXEC: begin
        case (cls_q)
          C_RTYPE, C_ADDI: state_d = WB;
          C_LW, C_SW:      state_d = MEM;
          default:         state_d = FETCH;
        endcase
      end
      MEM:     if (mem_ack) state_d = (cls_q == C_LW) ? WB : FETCH;
      WB:      state_d = FETCH;
      HALT:    state_d = HALT;
      default: state_d = FETCH;
    endcase
  end

  always_comb begin
    pc_we  = 1'b0;
    pc_sel = PC_SEQ;
    case (state_q)
      DECODE: pc_we = (op_cls == C_ILL);
      EXEC: begin
        if (cls_q == C_BEQ) begin
          pc_we  = 1'b1;
          pc_sel = zero ? PC_BR : PC_SEQ;
        end else if (cls_q == C_J) begin
          pc_we  = 1'b1;
          pc_sel = PC_JMP;
        end
      end
      MEM:     pc_we = mem_ack && (cls_q == C_SW);
      WB:      pc_we = 1'b1;
      default: pc_we = 1'b0;
    endcase
  end

  // Moore outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk or posedge rstd) begin
    if (rstd) begin
      state_q       <= FETCH;
      cls_q         <= C_RTYPE;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      rf_wren_q     <= 1'b1;
      alu_src_imm_q <= 1'b0;
      wb_sel_mem_q  <= 1'b0;
      halted_q      <= 1'b0;
      illegal_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cls_q         <= cls_d;
      mem_req_q     <= (state_d == FETCH) || (state_d == MEM);
      mem_we_q      <= (state_d == MEM) && (cls_d == C_SW);
      rf_wren_q     <= !((state_d == WB) && (wa != 5'd0));
      alu_src_imm_q <= (state_d == EXEC) && (cls_d inside {C_ADDI, C_LW, C_SW});
      wb_sel_mem_q  <= (state_d == WB) && (cls_d == C_LW);
      halted_q      <= (state_d == HALT);
      if ((state_q == DECODE) && (op_cls == C_ILL)) illegal_q <= 1'b1;
    end
  end

  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign rf_wren     = rf_wren_q;
  assign alu_src_imm = alu_src_imm_q;
  assign wb_sel_mem  = wb_sel_mem_q;
  assign halted      = halted_q;
  assign illegal     = illegal_q;

`ifdef MC_PERF_CNT_EN
  logic [31:0] retired_q;

  always_ff @(posedge clk or posedge rstd) begin
    if (rstd)       retired_q <= '0;
    else if (pc_we) retired_q <= retired_q + 32'd1;
  end

  assign retired = retired_q;
`else
  assign retired = '0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl; expected output vectors are hand-computed per cycle.
module tb_multicycle_ctrl;
  logic        clk = 1'b0;
  logic        rstd = 1'b1;
  logic [5:0]  opcode = '0;
  logic [4:0]  wa = '0;
  logic        zero = 1'b0;
  logic        mem_ack = 1'b0;
  logic        mem_req, mem_we, ir_we, pc_we, rf_wren, alu_src_imm, wb_sel_mem, halted, illegal;
  logic [1:0]  pc_sel;
  logic [31:0] retired;

  int n_chk = 0;
  int n_fail = 0;

`ifdef MC_PERF_CNT_EN
  localparam logic [31:0] RET_AFTER8 = 32'd8;
  localparam logic [31:0] RET_WRAP1  = 32'hFFFF_FFFF;
`else
  localparam logic [31:0] RET_AFTER8 = 32'd0;
  localparam logic [31:0] RET_WRAP1  = 32'd0;
`endif

  multicycle_ctrl dut (
    .clk(clk), .rstd(rstd), .opcode(opcode), .wa(wa), .zero(zero), .mem_ack(mem_ack),
    .mem_req(mem_req), .mem_we(mem_we), .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel),
    .rf_wren(rf_wren), .alu_src_imm(alu_src_imm), .wb_sel_mem(wb_sel_mem),
    .halted(halted), .illegal(illegal), .retired(retired)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Vector fields: mem_req mem_we ir_we pc_we _ pc_sel _ rf_wren _ alu_src_imm wb_sel_mem halted
  task automatic v(input string tag, input logic [9:0] exp);
    logic [9:0] obs;
    obs = {mem_req, mem_we, ir_we, pc_we, pc_sel, rf_wren, alu_src_imm, wb_sel_mem, halted};
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) if (!rstd) chk("ir_pc_excl", {31'd0, ir_we & pc_we}, 32'd0);

  initial begin
    // Reset, with a stray ack that must be ignored
    repeat (2) step();
    mem_ack = 1'b1; #1;
    v("reset", 10'b0000_00_1_000);
    chk("reset_illegal", {31'd0, illegal}, 32'd0);
    chk("reset_retired", retired, 32'd0);
    step(); rstd = 1'b0; mem_ack = 1'b0; #1;
    v("released_no_edge", 10'b0000_00_1_000);

    // R-type, wa=5, zero-wait ack
    step(); opcode = 6'd0; wa = 5'd5; mem_ack = 1'b1; #1;
    v("r_c1_fetch", 10'b1010_00_1_000);
    step(); mem_ack = 1'b0; #1; v("r_c2_dec", 10'b0000_00_1_000);
    step(); #1;                 v("r_c3_exec", 10'b0000_00_1_000);
    step(); #1;                 v("r_c4_wb", 10'b0001_00_0_000);

    // LW, wa=0, two MEM wait cycles
    step(); opcode = 6'd16; wa = 5'd0; mem_ack = 1'b1; #1;
    v("lw_c1_fetch", 10'b1010_00_1_000);
    step(); mem_ack = 1'b0; #1; v("lw_c2_dec", 10'b0000_00_1_000);
    step(); #1;                 v("lw_c3_exec", 10'b0000_00_1_100);
    step(); #1;                 v("lw_c4_mem_wait", 10'b1000_00_1_000);
    step(); #1;                 v("lw_c5_mem_wait", 10'b1000_00_1_000);
    step(); mem_ack = 1'b1; #1; v("lw_c6_mem_ack", 10'b1000_00_1_000);
    step(); mem_ack = 1'b0; #1; v("lw_c7_wb", 10'b0001_00_1_010);

    // SW, zero-wait
    step(); opcode = 6'd24; wa = 5'd3; mem_ack = 1'b1; #1;
    v("sw_c1_fetch", 10'b1010_00_1_000);
    step(); mem_ack = 1'b0; #1; v("sw_c2_dec", 10'b0000_00_1_000);
    step(); #1;                 v("sw_c3_exec", 10'b0000_00_1_100);
    step(); mem_ack = 1'b1; #1; v("sw_c4_mem", 10'b1101_00_1_000);

    // BEQ taken / not taken, J
    step(); opcode = 6'd32; mem_ack = 1'b1; #1; v("beq1_c1_fetch", 10'b1010_00_1_000);
    step(); mem_ack = 1'b0; #1;                 v("beq1_c2_dec", 10'b0000_00_1_000);
    step(); zero = 1'b1; #1;                    v("beq1_c3_exec", 10'b0001_01_1_000);
    step(); mem_ack = 1'b1; zero = 1'b0; #1;    v("beq0_c1_fetch", 10'b1010_00_1_000);
    step(); mem_ack = 1'b0; #1;                 v("beq0_c2_dec", 10'b0000_00_1_000);
    step(); #1;                                 v("beq0_c3_exec", 10'b0001_00_1_000);
    step(); opcode = 6'd40; mem_ack = 1'b1; #1; v("j_c1_fetch", 10'b1010_00_1_000);
    step(); mem_ack = 1'b0; zero = 1'b1; #1;    v("j_c2_dec", 10'b0000_00_1_000);
    step(); #1;                                 v("j_c3_exec", 10'b0001_10_1_000);

    // Illegal opcode 7
    step(); opcode = 6'd7; zero = 1'b0; mem_ack = 1'b1; #1;
    v("ill_c1_fetch", 10'b1010_00_1_000);
    step(); mem_ack = 1'b0; #1;
    v("ill_c2_dec", 10'b0001_00_1_000);
    chk("ill_flag_in_dec", {31'd0, illegal}, 32'd0);
    step(); #1;
    v("ill_next_fetch", 10'b1000_00_1_000);
    chk("ill_flag_set", {31'd0, illegal}, 32'd1);

    // ADDI wa=2 with one fetch wait; acks in DECODE/EXEC are ignored
    opcode = 6'd1; wa = 5'd2;
    step(); mem_ack = 1'b1; #1; v("addi_c2_fetch_ack", 10'b1010_00_1_000);
    step(); #1;                 v("addi_c3_dec", 10'b0000_00_1_000);
    step(); #1;                 v("addi_c4_exec", 10'b0000_00_1_100);
    step(); mem_ack = 1'b0; #1; v("addi_c5_wb", 10'b0001_00_0_000);
    chk("ill_sticky", {31'd0, illegal}, 32'd1);
    chk("retired_8", retired, RET_AFTER8);

    // Counter wrap across two instructions
    step(); #1;
`ifdef MC_PERF_CNT_EN
    force dut.retired_q = 32'hFFFF_FFFE;
    #1;
    release dut.retired_q;
    #1;
    chk("retired_preload", retired, 32'hFFFF_FFFE);
`endif
    opcode = 6'd40; mem_ack = 1'b1; #1; v("wrap_j_fetch", 10'b1010_00_1_000);
    step(); mem_ack = 1'b0; #1; v("wrap_j_dec", 10'b0000_00_1_000);
    step(); #1;                 v("wrap_j_exec", 10'b0001_10_1_000);
    step(); opcode = 6'd32; zero = 1'b0; mem_ack = 1'b1; #1;
    chk("retired_wrap1", retired, RET_WRAP1);
    step(); mem_ack = 1'b0; #1; v("wrap_beq_dec", 10'b0000_00_1_000);
    step(); #1;                 v("wrap_beq_exec", 10'b0001_00_1_000);
    step(); #1;
    chk("retired_wrap0", retired, 32'd0);

    // Reset while SW waits in MEM
    opcode = 6'd24; wa = 5'd3; mem_ack = 1'b1; #1; v("swr_c1_fetch", 10'b1010_00_1_000);
    step(); mem_ack = 1'b0; #1; v("swr_c2_dec", 10'b0000_00_1_000);
    step(); #1;                 v("swr_c3_exec", 10'b0000_00_1_100);
    step(); #1;                 v("swr_c4_mem_wait", 10'b1100_00_1_000);
    rstd = 1'b1; mem_ack = 1'b1; #1;
    v("swr_in_reset", 10'b0000_00_1_000);
    chk("swr_retired", retired, 32'd0);
    chk("swr_illegal_clr", {31'd0, illegal}, 32'd0);
    step(); #1; v("swr_reset_hold", 10'b0000_00_1_000);
    rstd = 1'b0; mem_ack = 1'b0; #1;
    v("swr_released", 10'b0000_00_1_000);
    step(); #1;
    v("swr_mreq_back", 10'b1000_00_1_000);
    chk("swr_retired_after", retired, 32'd0);

    // HALT is absorbing
    opcode = 6'd63; mem_ack = 1'b1; #1; v("halt_c1_fetch", 10'b1010_00_1_000);
    step(); mem_ack = 1'b0; #1; v("halt_c2_dec", 10'b0000_00_1_000);
    step(); #1;                 v("halt_c3", 10'b0000_00_1_001);
    for (int i = 0; i < 20; i++) begin
      step(); mem_ack = i[0]; opcode = 6'd0; wa = 5'd7; #1;
      v("halt_hold", 10'b0000_00_1_001);
    end
    chk("halt_retired", retired, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 The block SHALL have these ports: clk, input, 1, rising-edge clock.
REQ-002 The block SHALL have these ports: rstd, input, 1, asynchronous reset, active-high.
REQ-003 The block SHALL have these ports: opcode, input, 6, instruction-register opcode field.
REQ-004 The block SHALL have these ports: wa, input, 5, destination register address of the current instruction.
REQ-005 The block SHALL have these ports: zero, input, 1, ALU zero flag, valid in EXEC.
REQ-006 The block SHALL have these ports: mem_ack, input, 1, memory completion strobe.
REQ-007 The block SHALL have these outputs: mem_req (1, memory request), mem_we (1, memory write), ir_we (1, instruction-register load) and pc_we (1, PC register load).
REQ-008 The block SHALL have these outputs: pc_sel (2; 0 = pc+4, 1 = branch target, 2 = jump target), rf_wren (1, register-file write enable, active-low), alu_src_imm (1), wb_sel_mem (1) and halted (1).
REQ-009 The block SHALL have these outputs: illegal (1, sticky illegal-opcode flag) and retired (32, retired-instruction count).

Function
REQ-010 The FSM SHALL have the states FETCH, DECODE, EXEC, MEM, WB and HALT, and SHALL enter FETCH on reset release.
REQ-011 In FETCH, the block SHALL drive mem_req=1 and mem_we=0, hold the state until mem_ack=1, then pulse ir_we=1 in the ack cycle and move to DECODE.
REQ-012 DECODE SHALL last one cycle and classify opcode as follows: 0 = R-type, 1 = ADDI, 16 = LW, 24 = SW, 32 = BEQ, 40 = J, 63 = HALT; all other opcodes are illegal.
REQ-013 In DECODE, HALT SHALL go to HALT; an illegal opcode SHALL set illegal, pulse pc_we with pc_sel=0 and return to FETCH; all other opcodes SHALL go to EXEC.
REQ-014 EXEC SHALL last one cycle; alu_src_imm SHALL be 1 for ADDI, LW and SW.
REQ-015 From EXEC, R-type and ADDI SHALL go to WB, and LW and SW SHALL go to MEM.
REQ-016 From EXEC, BEQ SHALL pulse pc_we with pc_sel=1 if zero=1, else pc_sel=0, and SHALL return to FETCH.
REQ-017 From EXEC, J SHALL pulse pc_we with pc_sel=2 and return to FETCH.
REQ-018 MEM SHALL drive mem_req=1 and set mem_we=1 for SW only, and SHALL hold until mem_ack.
REQ-019 On mem_ack in MEM, SW SHALL pulse pc_we with pc_sel=0 and return to FETCH; LW SHALL go to WB.
REQ-020 WB SHALL last one cycle and drive rf_wren=0 unless wa=0; a write to register 0 SHALL be suppressed by holding rf_wren=1.
REQ-021 In WB, wb_sel_mem SHALL be 1 for LW, pc_we SHALL pulse with pc_sel=0, and the FSM SHALL return to FETCH.
REQ-022 HALT SHALL be absorbing until reset, with halted=1, all strobes deasserted and rf_wren=1.
REQ-023 mem_ack SHALL be ignored outside FETCH and MEM.
REQ-024 With a zero-wait mem_ack, latency SHALL be 4 cycles for R-type, ADDI, SW and 3 cycles for BEQ, J; each wait cycle adds one cycle.
REQ-025 pc_we and ir_we SHALL never be asserted in the same cycle, and pc_we SHALL pulse exactly once per completed instruction.
REQ-026 All outputs SHALL be registered-state decodes (Moore) except the ack-qualified strobes ir_we and pc_we.

Reset
REQ-027 While rstd=1, the FSM SHALL be in FETCH with mem_req=0 and mem_we=0.
REQ-028 While rstd=1, ir_we, pc_we, pc_sel, alu_src_imm, wb_sel_mem, halted, illegal and retired SHALL all be 0, and rf_wren SHALL be 1.
REQ-029 Reset asserted mid-instruction, including in MEM awaiting ack, SHALL abandon the instruction without issuing pc_we or a register write.
REQ-030 mem_req SHALL assert in the first clock edge after rstd falls.

Configuration
REQ-031 When MC_PERF_CNT_EN is defined, retired SHALL increment by 1 on every pc_we pulse, including illegal-opcode skips, and SHALL wrap from 0xFFFFFFFF to 0.
REQ-032 When MC_PERF_CNT_EN is undefined, retired SHALL be constant 0 and no counter register SHALL be synthesized.

Verification
REQ-033 The bench SHALL cover: reset, then R-type with wa=5 and mem_ack=1 immediately -> ir_we at cycle 1, rf_wren=0 at cycle 4, pc_we with pc_sel=0 at cycle 4.
REQ-034 The bench SHALL cover: LW with wa=0 and 2 wait cycles in MEM -> rf_wren stays 1 throughout, pc_we at cycle 7, wb_sel_mem=1 in WB.
REQ-035 The bench SHALL cover: BEQ with zero=1 -> pc_sel=1 with pc_we at cycle 3; BEQ with zero=0 -> pc_sel=0.
REQ-036 The bench SHALL cover: opcode 7 -> illegal=1 stays set, pc_we in DECODE, next FETCH follows; opcode 63 -> halted=1 and no mem_req for 20 cycles.
REQ-037 The bench SHALL cover: rstd pulsed while in MEM for SW -> no pc_we, retired=0, mem_req reasserts after release.
REQ-038 The bench SHALL cover, with MC_PERF_CNT_EN, retired forced to 0xFFFFFFFE plus 2 completed instructions -> retired=0.
